gx4000_cpr_loader: RTL and testbench
====================================

// Module: gx4000_cpr_loader
// PURPOSE
// Streams a .CPR cartridge image (RIFF "AMS!" container) from the HPS ioctl download port, parses it on the fly
// and emits one byte write per payload byte into cartridge memory at bank*BANK_BYTES+offset.
// Sits directly upstream of the cartridge/memory stage and feeds its write port and auto-boot logic.
// Reports completion, loaded-bank map and a parse error code.
// PARAMETERS
// MAX_BANKS   32     highest legal bank is MAX_BANKS-1 (cb00..cb31)
// BANK_BYTES  16384  bank stride; cb chunk larger than this is an error
// ADDR_W      19     mem_addr width = log2(MAX_BANKS*BANK_BYTES)
// PORTS
// clk_sys        in   1       system clock
// reset          in   1       asynchronous, active-high
// ioctl_download in   1       download window active (this image targeted)
// ioctl_wr       in   1       one-cycle strobe, one image byte
// ioctl_addr     in   25      byte index in image; used only for restart detection
// ioctl_dout     in   8       image byte
// mem_addr       out  ADDR_W  cartridge memory write address
// mem_data       out  8       write data
// mem_wr         out  1       one-cycle write strobe
// bank_loaded    out  32      bit n set when chunk cbNN (n) seen
// busy           out  1       parser active
// done           out  1       image parsed OK; held until next download
// error          out  1       parse failed; held until next download
// err_code       out  3       1 RIFF tag,2 AMS! tag,3 bad bank id,4 chunk too large,5 truncated
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE.
// - Rising ioctl_download, or ioctl_wr with ioctl_addr==0: clear bank_loaded/done/error/err_code, enter RIFF_ID
//   (byte at addr 0 is consumed as first RIFF byte). busy=1 in every state except IDLE/DONE/ERROR.
// - Multi-byte fields parsed by 2-bit byte counter; lengths little-endian 32-bit.
// - States: RIFF_ID("RIFF") -> RIFF_LEN(ignored) -> FORM_ID("AMS!") -> CHUNK_ID -> CHUNK_LEN
//   -> CHUNK_DATA | SKIP -> [PAD] -> CHUNK_ID; terminal DONE, ERROR.
// - Tag mismatch checked per byte; first bad byte -> ERROR with code 1/2 at that byte.
// - CHUNK_ID: "cb" + two ASCII decimal digits -> data chunk; digit not '0'-'9' or value>=MAX_BANKS -> ERROR 3.
//   Any other 4-byte id -> SKIP chunk (payload consumed, no writes).
// - CHUNK_LEN: cb chunk with length>BANK_BYTES -> ERROR 4; any chunk with length>=2^24 -> ERROR 4.
//   Length 0: set bank bit, go to CHUNK_ID directly. Odd length: one pad byte consumed after payload.
// - CHUNK_DATA: byte k (0-based) -> mem_addr=bank*BANK_BYTES+k, mem_data=byte, mem_wr=1 exactly one cycle
//   after the ioctl_wr cycle (registered, latency 1). Bank bit set on first data byte or on zero length.
//   Short chunk leaves remainder of bank untouched. Duplicate bank id: rewrites, no error.
// - Falling ioctl_download: in CHUNK_ID with byte counter 0 and bank_loaded!=0 -> DONE (done=1);
//   bank_loaded==0 or any other non-terminal state -> ERROR 5. In IDLE/DONE/ERROR: no change.
// - ERROR/DONE: further ioctl_wr ignored, mem_wr never asserted, until restart condition.
// - ioctl_wr while ioctl_download low: ignored. Back-to-back ioctl_wr every cycle supported.
// - Async reset mid-stream: outputs 0 at once; partial bank contents in memory are not cleaned.
// TESTING
// - Min image "RIFF",len,"AMS!","cb00",len=4,DE AD BE EF -> mem_wr x4 at 0..3, bank_loaded=1, done=1 on drop.
// - "cb31" len 3 bytes 11 22 33 + pad + "cb01" len 2 -> writes 0x7C000..0x7C002, 0x4000..0x4001; pad not written.
// - "fmt " chunk len 5 before cb00 -> 5 bytes + pad skipped, zero writes, then cb00 loads normally.
// - "cb32" -> error=1, err_code=3, no mem_wr thereafter; "cb0x" -> err_code=3.
// - cb02 len 0x4001 -> err_code=4; byte 2 of header 'F'->'X' -> err_code=1 immediately.
// - Download drops mid CHUNK_DATA -> err_code=5; new download (addr 0) clears error and reparses cleanly.

Source files
------------

// File: rtl/gx4000_cpr_loader_if.sv
// -----------------------------------------------------------------------------
// gx4000_cpr_loader_if
// Bundles the HPS ioctl download stream and the cartridge memory write port
// seen by the .CPR loader.
//
//   ioctl_download  download window active for this image
//   ioctl_wr        one-cycle strobe, one image byte on ioctl_dout
//   ioctl_addr      byte index in the image (restart detection only)
//   ioctl_dout      image byte
//   mem_addr        cartridge memory write address (bank*BANK_BYTES+offset)
//   mem_data        write data
//   mem_wr          one-cycle write strobe
//
// master: the side that supplies the image and consumes memory writes.
// slave : the loader itself.
// -----------------------------------------------------------------------------
interface gx4000_cpr_loader_if #(
    parameter int ADDR_W = 19
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_wr;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  mem_addr, mem_data, mem_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output mem_addr, mem_data, mem_wr
    );
endinterface

// File: rtl/gx4000_cpr_loader.sv
// -----------------------------------------------------------------------------
// gx4000_cpr_loader
// Streams a .CPR cartridge image (RIFF "AMS!" container) from the ioctl
// download port, parses it on the fly and issues one memory write per payload
// byte of every "cbNN" chunk at address NN*BANK_BYTES+offset.
//
// Ports:
//   clk_sys      system clock
//   reset        asynchronous, active-high
//   bus          ioctl download stream in, memory write port out (slave side)
//   bank_loaded  bit n set once chunk cbNN with NN==n has been seen
//   busy         parser active (any state except IDLE/DONE/ERROR)
//   done         image parsed OK; held until the next download
//   error        parse failed; held until the next download
//   err_code     1 RIFF tag, 2 AMS! tag, 3 bad bank id, 4 chunk too large,
//                5 truncated image
// -----------------------------------------------------------------------------
module gx4000_cpr_loader #(
    parameter int MAX_BANKS  = 32,
    parameter int BANK_BYTES = 16384,
    parameter int ADDR_W     = 19
) (
    input  logic                clk_sys,
    input  logic                reset,
    gx4000_cpr_loader_if.slave  bus,
    output logic [31:0]         bank_loaded,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [2:0]          err_code
);

    localparam int BANK_W = $clog2(MAX_BANKS);
    localparam int OFF_W  = $clog2(BANK_BYTES);

    localparam logic [31:0] RIFF_TAG = 32'h5249_4646;  // "RIFF"
    localparam logic [31:0] FORM_TAG = 32'h414D_5321;  // "AMS!"
    localparam logic [15:0] CB_TAG   = 16'h6362;       // "cb"

    typedef enum logic [3:0] {
        S_IDLE, S_RIFF_ID, S_RIFF_LEN, S_FORM_ID, S_CHUNK_ID, S_CHUNK_LEN,
        S_CHUNK_DATA, S_SKIP, S_PAD, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_RIFF  = 3'd1,
        ERR_FORM  = 3'd2,
        ERR_BANK  = 3'd3,
        ERR_SIZE  = 3'd4,
        ERR_TRUNC = 3'd5
    } err_t;

    // Registered state
    state_t              state_q,  state_n;
    logic [1:0]          cnt_q,    cnt_n;      // byte index inside 4-byte fields
    logic [23:0]         id_q,     id_n;       // first three chunk id bytes
    logic [23:0]         len_q,    len_n;      // low three length bytes (LE)
    logic [23:0]         remain_q, remain_n;   // payload bytes still to consume
    logic [OFF_W-1:0]    off_q,    off_n;      // write offset inside the bank
    logic [BANK_W-1:0]   bank_q,   bank_n;
    logic                is_cb_q,  is_cb_n;
    logic                odd_q,    odd_n;
    logic [31:0]         bank_loaded_q, bank_loaded_n;
    err_t                err_q,    err_n;
    logic                dl_q;
    logic                mem_wr_q,   wr_n;
    logic [ADDR_W-1:0]   mem_addr_q, waddr_n;
    logic [7:0]          mem_data_q, wdata_n;

    // Input events
    logic       byte_in, restart, fall;
    logic [7:0] din;

    assign din     = bus.ioctl_dout;
    assign byte_in = bus.ioctl_download & bus.ioctl_wr;
    // A rising window or a write to image byte 0 restarts the parse; the byte
    // at address 0 is then consumed as the first "RIFF" byte in the same cycle.
    assign restart = bus.ioctl_download &
                     (~dl_q | (bus.ioctl_wr & (bus.ioctl_addr == 25'd0)));
    assign fall    = ~bus.ioctl_download & dl_q;

    // Chunk id decode on its fourth byte
    logic [31:0] full_id;
    logic [7:0]  dig_hi, dig_lo, bank_val;
    logic        id_is_cb, digits_ok;

    assign full_id   = {id_q, din};
    assign id_is_cb  = (full_id[31:16] == CB_TAG);
    assign dig_hi    = full_id[15:8] - 8'h30;
    assign dig_lo    = full_id[7:0]  - 8'h30;
    // Unsigned wrap makes characters below '0' fail the < 10 test as well.
    assign digits_ok = (dig_hi < 8'd10) && (dig_lo < 8'd10);
    assign bank_val  = dig_hi * 8'd10 + dig_lo;

    function automatic logic [7:0] tag_byte(input logic [31:0] tag, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = tag[31:24];
            2'd1:    b = tag[23:16];
            2'd2:    b = tag[15:8];
            default: b = tag[7:0];
        endcase
        return b;
    endfunction

    state_t     cur_state;
    logic [1:0] cur_cnt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
        cur_state     = state_q;
        cur_cnt       = cnt_q;
        bank_loaded_n = bank_loaded_q;
        err_n         = err_q;
        if (restart) begin
            cur_state     = S_RIFF_ID;
            cur_cnt       = 2'd0;
            bank_loaded_n = '0;
            err_n         = ERR_NONE;
        end
        state_n  = cur_state;
        cnt_n    = cur_cnt;
        id_n     = id_q;
        len_n    = len_q;
        remain_n = remain_q;
        off_n    = off_q;
        bank_n   = bank_q;
        is_cb_n  = is_cb_q;
        odd_n    = odd_q;
        wr_n     = 1'b0;
        waddr_n  = mem_addr_q;
        wdata_n  = mem_data_q;

        if (fall) begin
            case (cur_state)
                S_IDLE, S_DONE, S_ERROR: ;
                // Only a clean chunk boundary after at least one bank is a
                // complete image.
                S_CHUNK_ID: begin
                    if (cur_cnt == 2'd0 && bank_loaded_q != '0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ERROR;
                        err_n   = ERR_TRUNC;
                    end
                end
                default: begin
                    state_n = S_ERROR;
                    err_n   = ERR_TRUNC;
                end
            endcase
        end else if (byte_in) begin
            case (cur_state)
                S_RIFF_ID: begin
                    if (din != tag_byte(RIFF_TAG, cur_cnt)) begin
                        state_n = S_ERROR;
                        err_n   = ERR_RIFF;
                    end else begin
                        cnt_n = cur_cnt + 2'd1;
                        if (cur_cnt == 2'd3) state_n = S_RIFF_LEN;
                    end
                end
                S_RIFF_LEN: begin
                    cnt_n = cur_cnt + 2'd1;
                    if (cur_cnt == 2'd3) state_n = S_FORM_ID;
                end
                S_FORM_ID: begin
                    if (din != tag_byte(FORM_TAG, cur_cnt)) begin
                        state_n = S_ERROR;
                        err_n   = ERR_FORM;
                    end else begin
                        cnt_n = cur_cnt + 2'd1;
                        if (cur_cnt == 2'd3) state_n = S_CHUNK_ID;
                    end
                end
                S_CHUNK_ID: begin
                    cnt_n = cur_cnt + 2'd1;
                    id_n  = {id_q[15:0], din};
                    if (cur_cnt == 2'd3) begin
                        if (id_is_cb) begin
                            if (!digits_ok || bank_val >= 8'(MAX_BANKS)) begin
                                state_n = S_ERROR;
                                err_n   = ERR_BANK;
                            end else begin
                                is_cb_n = 1'b1;
                                bank_n  = BANK_W'(bank_val);
                                state_n = S_CHUNK_LEN;
                            end
                        end else begin
                            is_cb_n = 1'b0;
                            state_n = S_CHUNK_LEN;
                        end
                    end
                end
                S_CHUNK_LEN: begin
                    cnt_n = cur_cnt + 2'd1;
                    len_n = {din, len_q[23:8]};
                    if (cur_cnt == 2'd3) begin
                        // len_q holds the low 24 bits; din is the top byte.
                        if (din != 8'd0 || (is_cb_q && len_q > 24'(BANK_BYTES))) begin
                            state_n = S_ERROR;
                            err_n   = ERR_SIZE;
                        end else if (len_q == 24'd0) begin
                            if (is_cb_q) bank_loaded_n[bank_q] = 1'b1;
                            state_n = S_CHUNK_ID;
                        end else begin
                            remain_n = len_q;
                            odd_n    = len_q[0];
                            off_n    = '0;
                            state_n  = is_cb_q ? S_CHUNK_DATA : S_SKIP;
                        end
                    end
                end
                S_CHUNK_DATA, S_SKIP: begin
                    if (cur_state == S_CHUNK_DATA) begin
                        wr_n    = 1'b1;
                        waddr_n = ADDR_W'(bank_q) * ADDR_W'(BANK_BYTES) + ADDR_W'(off_q);
                        wdata_n = din;
                        bank_loaded_n[bank_q] = 1'b1;
                    end
                    off_n    = off_q + 1'b1;
                    remain_n = remain_q - 24'd1;
                    if (remain_q == 24'd1) state_n = odd_q ? S_PAD : S_CHUNK_ID;
                end
                S_PAD:   state_n = S_CHUNK_ID;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            id_q          <= '0;
            len_q         <= '0;
            remain_q      <= '0;
            off_q         <= '0;
            bank_q        <= '0;
            is_cb_q       <= 1'b0;
            odd_q         <= 1'b0;
            bank_loaded_q <= '0;
            err_q         <= ERR_NONE;
            dl_q          <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            id_q          <= id_n;
            len_q         <= len_n;
            remain_q      <= remain_n;
            off_q         <= off_n;
            bank_q        <= bank_n;
            is_cb_q       <= is_cb_n;
            odd_q         <= odd_n;
            bank_loaded_q <= bank_loaded_n;
            err_q         <= err_n;
            dl_q          <= bus.ioctl_download;
            mem_wr_q      <= wr_n;
            mem_addr_q    <= waddr_n;
            mem_data_q    <= wdata_n;
        end
    end

    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;

    assign bank_loaded = bank_loaded_q;
    assign err_code    = err_q;
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);

endmodule

// File: tb/tb_gx4000_cpr_loader.sv
// -----------------------------------------------------------------------------
// tb_gx4000_cpr_loader
// Directed bench for the .CPR loader: builds small images byte by byte,
// streams them back-to-back through the ioctl port and checks the memory
// write log and status outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_gx4000_cpr_loader;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] bank_loaded;
    logic        busy, done, error;
    logic [2:0]  err_code;

    gx4000_cpr_loader_if #(.ADDR_W(19)) bus ();

    gx4000_cpr_loader #(
        .MAX_BANKS (32),
        .BANK_BYTES(16384),
        .ADDR_W    (19)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus.slave),
        .bank_loaded(bank_loaded),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory write log, sampled 1 time unit after each rising edge
    typedef struct packed {
        logic [18:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wlog[$];

    always @(posedge clk_sys) begin
        #1;
        if (bus.mem_wr === 1'b1) wlog.push_back('{a: bus.mem_addr, d: bus.mem_data});
    end

    function automatic wr_t wr_at(input int i);
        if (i < wlog.size()) return wlog[i];
        return 'x;
    endfunction

    // Image construction and streaming
    logic [7:0]  img[$];
    int unsigned addr_ctr;

    task automatic add_tag(input string s);
        for (int i = 0; i < 4; i++) img.push_back(s[i]);
    endtask

    task automatic add_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) img.push_back(n[8*i +: 8]);
    endtask

    task automatic add_hdr();
        img.delete();
        add_tag("RIFF");
        add_len(32'h0000_0100);
        add_tag("AMS!");
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'(addr_ctr);
        bus.ioctl_dout = b;
        addr_ctr++;
    endtask

    task automatic send_img();
        foreach (img[i]) send_byte(img[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            bus.ioctl_wr = 1'b0;
        end
    endtask

    task automatic start_dl();
        @(negedge clk_sys);
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        bus.ioctl_download = 1'b1;
        addr_ctr = 0;
        wlog.delete();
    endtask

    task automatic drop_dl();
        @(negedge clk_sys);
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic min_image();
        add_hdr();
        add_tag("cb00");
        add_len(32'd4);
        img.push_back(8'hDE); img.push_back(8'hAD);
        img.push_back(8'hBE); img.push_back(8'hEF);
    endtask

    initial begin
        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        addr_ctr           = 0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_error", error, 0);
        check("rst_code",  err_code, 0);
        check("rst_banks", bank_loaded, 0);
        check("rst_memwr", bus.mem_wr, 0);
        reset = 1'b0;

        // Minimal image: cb00, 4 bytes
        start_dl();
        min_image();
        send_img();
        idle(1);
        check("min_lat_wr",   bus.mem_wr, 1);
        check("min_lat_addr", bus.mem_addr, 32'h3);
        check("min_lat_data", bus.mem_data, 32'hEF);
        idle(1);
        check("min_wr_off",   bus.mem_wr, 0);
        check("min_busy",     busy, 1);
        check("min_nwr",      32'(wlog.size()), 4);
        check("min_w0",       wr_at(0), {19'h0, 8'hDE});
        check("min_w1",       wr_at(1), {19'h1, 8'hAD});
        check("min_w2",       wr_at(2), {19'h2, 8'hBE});
        drop_dl();
        check("min_done",     done, 1);
        check("min_busy_end", busy, 0);
        check("min_banks",    bank_loaded, 32'h1);

        // cb31 odd length with pad, then cb01
        start_dl();
        idle(1);
        check("b31_clr_done",  done, 0);
        check("b31_clr_banks", bank_loaded, 0);
        check("b31_busy",      busy, 1);
        add_hdr();
        add_tag("cb31"); add_len(32'd3);
        img.push_back(8'h11); img.push_back(8'h22); img.push_back(8'h33); img.push_back(8'h00);
        add_tag("cb01"); add_len(32'd2);
        img.push_back(8'hAA); img.push_back(8'hBB);
        send_img();
        idle(2);
        check("b31_nwr", 32'(wlog.size()), 5);
        check("b31_w0",  wr_at(0), {19'h7C000, 8'h11});
        check("b31_w1",  wr_at(1), {19'h7C001, 8'h22});
        check("b31_w2",  wr_at(2), {19'h7C002, 8'h33});
        check("b31_w3",  wr_at(3), {19'h04000, 8'hAA});
        check("b31_w4",  wr_at(4), {19'h04001, 8'hBB});
        drop_dl();
        check("b31_done",  done, 1);
        check("b31_banks", bank_loaded, 32'h8000_0002);

        // Unknown chunk skipped, then odd-length cb00
        start_dl();
        add_hdr();
        add_tag("fmt "); add_len(32'd5);
        for (int i = 1; i <= 5; i++) img.push_back(8'(i));
        img.push_back(8'h00);
        add_tag("cb00"); add_len(32'd1);
        img.push_back(8'h5A); img.push_back(8'h00);
        send_img();
        idle(2);
        check("skip_nwr", 32'(wlog.size()), 1);
        check("skip_w0",  wr_at(0), {19'h0, 8'h5A});
        drop_dl();
        check("skip_done",  done, 1);
        check("skip_banks", bank_loaded, 32'h1);

        // Bank id out of range; later bytes must not write
        start_dl();
        add_hdr();
        add_tag("cb32");
        send_img();
        idle(1);
        check("cb32_err",  error, 1);
        check("cb32_code", err_code, 3);
        check("cb32_busy", busy, 0);
        img.delete();
        add_len(32'd4);
        for (int i = 0; i < 4; i++) img.push_back(8'hC0);
        send_img();
        idle(2);
        check("cb32_nwr", 32'(wlog.size()), 0);
        drop_dl();
        check("cb32_hold", err_code, 3);
        check("cb32_done", done, 0);

        // Non-digit bank id
        start_dl();
        add_hdr();
        add_tag("cb0x");
        send_img();
        idle(1);
        check("cb0x_code", err_code, 3);
        drop_dl();

        // cb chunk one byte over the bank size
        start_dl();
        add_hdr();
        add_tag("cb02"); add_len(32'h0000_4001);
        send_img();
        idle(1);
        check("big_err",  error, 1);
        check("big_code", err_code, 4);
        drop_dl();

        // Non-cb chunk with length >= 2^24
        start_dl();
        add_hdr();
        add_tag("abcd"); add_len(32'h0100_0000);
        send_img();
        idle(1);
        check("huge_code", err_code, 4);
        drop_dl();

        // Bad RIFF tag at byte 2, then restart by a write to address 0
        start_dl();
        send_byte(8'h52); send_byte(8'h49); send_byte(8'h58);
        idle(1);
        check("riff_err",  error, 1);
        check("riff_code", err_code, 1);
        addr_ctr = 0;
        wlog.delete();
        min_image();
        send_img();
        idle(2);
        check("re0_err",  error, 0);
        check("re0_code", err_code, 0);
        check("re0_nwr",  32'(wlog.size()), 4);
        drop_dl();
        check("re0_done", done, 1);

        // Bad form tag
        start_dl();
        img.delete();
        add_tag("RIFF"); add_len(32'd0); add_tag("AMX!");
        send_img();
        idle(1);
        check("form_code", err_code, 2);
        drop_dl();

        // Download drops inside chunk data, then a clean reload
        start_dl();
        add_hdr();
        add_tag("cb00"); add_len(32'd4);
        img.push_back(8'hDE); img.push_back(8'hAD);
        send_img();
        drop_dl();
        check("trunc_err",  error, 1);
        check("trunc_code", err_code, 5);
        check("trunc_nwr",  32'(wlog.size()), 2);
        start_dl();
        idle(1);
        check("rel_err",  error, 0);
        check("rel_code", err_code, 0);
        check("rel_busy", busy, 1);
        min_image();
        send_img();
        drop_dl();
        check("rel_done",  done, 1);
        check("rel_banks", bank_loaded, 32'h1);

        // Header only: no bank seen before the drop
        start_dl();
        add_hdr();
        send_img();
        drop_dl();
        check("nobank_code", err_code, 5);

        // Zero-length cb chunk marks the bank without writes
        start_dl();
        add_hdr();
        add_tag("cb05"); add_len(32'd0);
        send_img();
        drop_dl();
        check("zero_done",  done, 1);
        check("zero_banks", bank_loaded, 32'h20);
        check("zero_nwr",   32'(wlog.size()), 0);

        // Write strobes outside a download window are ignored
        addr_ctr = 0;
        send_byte(8'h52);
        idle(2);
        check("nodl_done", done, 1);
        check("nodl_nwr",  32'(wlog.size()), 0);

        // Asynchronous reset in the middle of chunk data
        start_dl();
        add_hdr();
        add_tag("cb00"); add_len(32'd4);
        img.push_back(8'hDE); img.push_back(8'hAD);
        send_img();
        idle(1);
        check("arst_pre_wr", bus.mem_wr, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_wr",    bus.mem_wr, 0);
        check("arst_busy",  busy, 0);
        check("arst_banks", bank_loaded, 0);
        check("arst_addr",  bus.mem_addr, 0);
        bus.ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
